// File: rtl/transport_pkg.sv
// -----------------------------------------------------------------------------
// transport_pkg
// Shared definitions for the transport layer (transmit and receive stages):
//   - packet header bytes for control and audio packets
//   - session command codes carried on sessionCmd
//   - framing FSM state encoding of the transmit stage
//   - helper computing the number of audio samples carried per packet
// -----------------------------------------------------------------------------
package transport_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_CTRL_HI = 3'd2,
        ST_CTRL_LO = 3'd3,
        ST_AUD_HI  = 3'd4,
        ST_AUD_LO  = 3'd5,
        ST_PAD     = 3'd6
    } tx_state_e;

    // One header byte and one trailing pad byte; everything else is 16-bit samples.
    function automatic int unsigned samples_per_packet(input int unsigned packet_size);
        return (packet_size - 2) / 2;
    endfunction

endpackage

// File: rtl/tx_sample_fifo.sv
// -----------------------------------------------------------------------------
// tx_sample_fifo
// Synchronous first-word-fall-through FIFO holding audio samples until the
// framing FSM has enough of them to build a packet.
// Ports:
//   clk    in   system clock
//   srst   in   synchronous active-high reset (flushes pointers and count)
//   wr_en  in   push din (ignored while full)
//   din    in   sample to push
//   rd_en  in   pop the head entry (ignored while empty)
//   dout   out  head entry, valid whenever count != 0
//   count  out  number of stored entries, 0..DEPTH
//   full   out  count == DEPTH
// -----------------------------------------------------------------------------
module tx_sample_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && (count_q != '0);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap by plain overflow.
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read after it was written, and resetting it would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/transport_send.sv
// -----------------------------------------------------------------------------
// transport_send
// Transmit-side transport stage. Collects control words (one-entry slot) and
// audio samples (FIFO) from the session layer, frames them into fixed-size
// packets and streams the packets one byte per strobe to the network layer.
//   control packet: 40, hi, lo, then PACKET_SIZE-3 pad bytes
//   audio packet:   80, S x {hi, lo}, then one pad byte, S = (PACKET_SIZE-2)/2
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   sessionCmd   in   01 control word valid, 10 audio sample valid, else none
//   sessionData  in   word qualified by sessionCmd
//   ctrlBusy     out  control slot occupied (control writes dropped)
//   audioFull    out  audio FIFO full (audio writes dropped)
//   netBusy      in   network cannot accept a byte this cycle
//   sendSignal   out  one-cycle strobe, packetOut valid
//   packetOut    out  outgoing byte (holds between strobes)
// -----------------------------------------------------------------------------
module transport_send
    import transport_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = 16,
    parameter int unsigned AUDIO_DEPTH = 32,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sessionCmd,
    input  logic [15:0] sessionData,
    output logic        ctrlBusy,
    output logic        audioFull,
    input  logic        netBusy,
    output logic        sendSignal,
    output logic [7:0]  packetOut
);

    localparam int unsigned S     = samples_per_packet(PACKET_SIZE);
    localparam int unsigned CNT_W = $clog2(PACKET_SIZE);
    localparam int unsigned FCW   = $clog2(AUDIO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(PACKET_SIZE - 1);
    // Byte index of the low half of the final sample in an audio packet.
    localparam logic [CNT_W-1:0] LAST_AUD_IDX = CNT_W'(PACKET_SIZE - 2);

    tx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             is_audio_q,  is_audio_d;
    logic             ctrl_busy_q, ctrl_busy_d;
    logic [15:0]      ctrl_word_q, ctrl_word_d;
    logic             send_q,      send_d;
    logic [7:0]       byte_q,      byte_d;

    // Byte the current state would emit and where it goes once emitted.
    logic [7:0]       tx_byte;
    tx_state_e        tx_next;
    logic             tx_pop;
    logic             tx_clr;

    logic             fifo_push;
    logic             fifo_pop;
    logic [15:0]      fifo_dout;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_full;

    // Acceptance looks at the registered full flag only: a pop in the same
    // cycle does not rescue a write.
    assign fifo_push = (sessionCmd == CMD_AUDIO) && !fifo_full;

    tx_sample_fifo #(
        .DEPTH (AUDIO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .wr_en (fifo_push),
        .din   (sessionData),
        .rd_en (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_audio_d  = is_audio_q;
        ctrl_busy_d = ctrl_busy_q;
        ctrl_word_d = ctrl_word_q;
        send_d      = 1'b0;
        byte_d      = byte_q;
        fifo_pop    = 1'b0;
        tx_byte     = PAD_BYTE;
        tx_next     = state_q;
        tx_pop      = 1'b0;
        tx_clr      = 1'b0;

        unique case (state_q)
            ST_IDLE: tx_next = ST_IDLE;
            ST_HDR: begin
                tx_byte = is_audio_q ? HDR_AUDIO : HDR_CTRL;
                tx_next = is_audio_q ? ST_AUD_HI : ST_CTRL_HI;
            end
            ST_CTRL_HI: begin
                tx_byte = ctrl_word_q[15:8];
                tx_next = ST_CTRL_LO;
            end
            ST_CTRL_LO: begin
                tx_byte = ctrl_word_q[7:0];
                tx_next = ST_PAD;
                tx_clr  = 1'b1;
            end
            ST_AUD_HI: begin
                tx_byte = fifo_dout[15:8];
                tx_next = ST_AUD_LO;
            end
            ST_AUD_LO: begin
                tx_byte = fifo_dout[7:0];
                tx_pop  = 1'b1;
                tx_next = (cnt_q == LAST_AUD_IDX) ? ST_PAD : ST_AUD_HI;
            end
            ST_PAD: begin
                tx_next = (cnt_q == LAST_IDX) ? ST_IDLE : ST_PAD;
            end
            default: tx_next = ST_IDLE;
        endcase

        if (state_q == ST_IDLE) begin
            // Packet boundary: a pending control word wins over audio, and
            // audio waits until a whole packet's worth of samples is queued.
            cnt_d = '0;
            if (ctrl_busy_q) begin
                state_d    = ST_HDR;
                is_audio_d = 1'b0;
            end else if (fifo_count >= FCW'(S)) begin
                state_d    = ST_HDR;
                is_audio_d = 1'b1;
            end
        end else if (!netBusy) begin
            // netBusy freezes state, counter and FIFO; only the strobe drops.
            state_d  = tx_next;
            send_d   = 1'b1;
            byte_d   = tx_byte;
            cnt_d    = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
            fifo_pop = tx_pop;
            if (tx_clr) ctrl_busy_d = 1'b0;
        end

        // Clear and accept never coincide: accepting needs the registered
        // busy flag low, clearing needs it high.
        if ((sessionCmd == CMD_CTRL) && !ctrl_busy_q) begin
            ctrl_busy_d = 1'b1;
            ctrl_word_d = sessionData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_audio_q  <= 1'b0;
            ctrl_busy_q <= 1'b0;
            ctrl_word_q <= '0;
            send_q      <= 1'b0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_audio_q  <= is_audio_d;
            ctrl_busy_q <= ctrl_busy_d;
            ctrl_word_q <= ctrl_word_d;
            send_q      <= send_d;
            byte_q      <= byte_d;
        end
    end

    assign ctrlBusy   = ctrl_busy_q;
    assign audioFull  = fifo_full;
    assign sendSignal = send_q;
    assign packetOut  = byte_q;

endmodule
